register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of registers (power of two, 2..64).
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 reads as zero and ignores writes when 1.
REQ-004 The block SHALL derive AW = log2(DEPTH) for all address ports.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  write-back strobe.
REQ-008 wr_addr  input  AW  write-back register index.
REQ-009 wr_data  input  WIDTH  write-back data.
REQ-010 rd_en1, rd_en2  input  1 each  read-port enables.
REQ-011 rd_addr1, rd_addr2  input  AW each  read-port indices.
REQ-012 rd_data1, rd_data2  output  WIDTH each  read-port data.
REQ-013 iss_en  input  1  issue strobe: marks destination pending.
REQ-014 iss_addr  input  AW  issuing instruction's destination index.
REQ-015 busy1, busy2  output  1 each  source register pending write-back.
REQ-016 stall  output  1  hazard indication to issue logic.

Function
REQ-017 Storage SHALL be DEPTH x WIDTH flip-flops plus a DEPTH-bit busy vector, all on clk.
REQ-018 Reads SHALL be combinational (zero latency); writes SHALL take effect at the next rising edge.
REQ-019 rd_dataN SHALL be all-zeros when rd_enN is 0 (no tristate or high-Z outputs).
REQ-020 When rd_enN=1, wr_en=1 and wr_addr==rd_addrN, rd_dataN SHALL equal wr_data in the same cycle (write-to-read bypass).
REQ-021 Otherwise, rd_dataN SHALL equal the stored register contents when rd_enN=1.
REQ-022 With ZERO_REG=1, reads of index 0 SHALL return 0, including under bypass; writes and issues to index 0 SHALL be ignored; busy[0] SHALL stay 0.
REQ-023 iss_en=1 SHALL set busy[iss_addr] at the next edge.
REQ-024 wr_en=1 SHALL clear busy[wr_addr] at the next edge.
REQ-025 Simultaneous iss_en and wr_en to the same index SHALL leave busy set (new writer wins).
REQ-026 Simultaneous iss_en and wr_en to different indices SHALL both take effect.
REQ-027 busyN SHALL be busy[rd_addrN] AND rd_enN, forced to 0 when wr_en=1 and wr_addr==rd_addrN (consistent with bypass).
REQ-028 stall SHALL be busy1 OR busy2, combinational.
REQ-029 iss_en to an already-busy index SHALL keep it busy without error; wr_en to a non-busy index SHALL write data and leave busy clear.
REQ-030 Out-of-range indices cannot occur (DEPTH is a power of two); no range checks SHALL be added.

Reset
REQ-031 While rst=0 at a rising edge, all registers SHALL clear to 0 and all busy bits SHALL clear to 0.
REQ-032 wr_en and iss_en SHALL be ignored at any edge where rst=0, including mid-sequence.
REQ-033 Combinational outputs SHALL still follow REQ-019..REQ-028 during reset, with bypass active; after the reset edge, all reads return 0 and stall=0.

Verification
REQ-034 Reset then read all indices on both ports -> rd_data1/2=0x0000, busy1/2=0, stall=0.
REQ-035 Write 0xBEEF to r5; next cycle rd_addr1=5, rd_en1=1 -> rd_data1=0xBEEF; with rd_en1=0 -> rd_data1=0x0000.
REQ-036 Same cycle: wr_en=1, wr_addr=7, wr_data=0x1234, rd_addr2=7, rd_en2=1 -> rd_data2=0x1234 before the edge.
REQ-037 Write 0xFFFF to r0 (ZERO_REG=1), then read r0 -> 0x0000; iss_en on r0 -> busy stays 0.
REQ-038 iss r3; next cycle read r3 on port 1 -> busy1=1, stall=1; write-back r3 with 0x00AA -> same-cycle busy1=0, stall=0, rd_data1=0x00AA; next cycle busy1=0.
REQ-039 Busy r4, then same edge iss_en=1/wr_en=1 on r4 -> r4 stays busy; then rst=0 for one edge -> busy clear, r4=0x0000.

Source files
------------

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : register_file_sb
// Description : Register file with scoreboard. DEPTH x WIDTH registers with
//               one write-back port and two combinational read ports, plus a
//               per-register busy bit. The busy bit marks a destination whose
//               write-back is still outstanding, so issue logic can stall.
//
// Ports       : clk                  - clock, all state updates on rising edge
//               rst                  - synchronous reset, active low
//               wr_en/wr_addr/wr_data - write-back; clears the busy bit
//               rd_en1/rd_addr1      - read port 1 enable and index
//               rd_en2/rd_addr2      - read port 2 enable and index
//               rd_data1/rd_data2    - read data (zero when the port is idle)
//               iss_en/iss_addr      - issue; sets the destination busy bit
//               busy1/busy2          - source register of port N is pending
//               stall                - either source is pending
//
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en1,
    input  logic [$clog2(DEPTH)-1:0] rd_addr1,
    output logic [WIDTH-1:0]         rd_data1,
    input  logic                     rd_en2,
    input  logic [$clog2(DEPTH)-1:0] rd_addr2,
    output logic [WIDTH-1:0]         rd_data2,
    input  logic                     iss_en,
    input  logic [$clog2(DEPTH)-1:0] iss_addr,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic c_zero_en = (ZERO_REG != 0);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;

    // Register 0 is hard-wired when c_zero_en: writes and issues to it are
    // dropped here so neither its data nor its busy bit can ever change.
    logic w_wr_ok;
    logic w_iss_ok;
    logic w_hit1;
    logic w_hit2;

    assign w_wr_ok  = wr_en  && !(c_zero_en && (wr_addr  == '0));
    assign w_iss_ok = iss_en && !(c_zero_en && (iss_addr == '0));

    // Same-cycle write to the index being read: the port sees the new data,
    // so it must not report the register as pending either.
    assign w_hit1 = wr_en && (wr_addr == rd_addr1);
    assign w_hit2 = wr_en && (wr_addr == rd_addr2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                // Issue takes priority over write-back on the same index:
                // the newly issued instruction is the outstanding writer.
                if (w_iss_ok && (iss_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_ok && (wr_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read port 1
    always_comb begin
        rd_data1 = '0;
        if (rd_en1) begin
            if (c_zero_en && (rd_addr1 == '0)) begin
                rd_data1 = '0;
            end else if (w_hit1) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = r_regs[rd_addr1];
            end
        end
    end

    // Read port 2
    always_comb begin
        rd_data2 = '0;
        if (rd_en2) begin
            if (c_zero_en && (rd_addr2 == '0)) begin
                rd_data2 = '0;
            end else if (w_hit2) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = r_regs[rd_addr2];
            end
        end
    end

    assign busy1 = rd_en1 && r_busy[rd_addr1] && !w_hit1;
    assign busy2 = rd_en2 && r_busy[rd_addr2] && !w_hit2;
    assign stall = busy1 || busy2;

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_sb
// Description : Directed self-checking bench for register_file_sb with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_sb;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en1;
    logic [AW-1:0]    rd_addr1;
    logic [WIDTH-1:0] rd_data1;
    logic             rd_en2;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] rd_data2;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             busy1;
    logic             busy2;
    logic             stall;

    int checks;
    int failures;

    register_file_sb #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy1    (busy1),
        .busy2    (busy2),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en1   = 1'b0;
        rd_addr1 = '0;
        rd_en2   = 1'b0;
        rd_addr2 = '0;
        iss_en   = 1'b0;
        iss_addr = '0;

        tick();
        tick();
        rst = 1'b1;

        // Reset state: every index reads zero and nothing is busy.
        rd_en1 = 1'b1;
        rd_en2 = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr1 = AW'(i);
            rd_addr2 = AW'(DEPTH - 1 - i);
            #1;
            check("reset_rd1", rd_data1, 16'h0000);
            check("reset_rd2", rd_data2, 16'h0000);
            check("reset_busy1", {15'd0, busy1}, 16'h0000);
            check("reset_busy2", {15'd0, busy2}, 16'h0000);
            check("reset_stall", {15'd0, stall}, 16'h0000);
        end
        rd_en2 = 1'b0;

        // Plain write to r5, read next cycle; disabled port reads zero.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        rd_addr1 = 4'd2;
        tick();
        wr_en = 1'b0;
        rd_addr1 = 4'd5;
        #1;
        check("r5_read", rd_data1, 16'hBEEF);
        check("r5_notbusy", {15'd0, busy1}, 16'h0000);
        rd_en1 = 1'b0;
        #1;
        check("r5_rd_disabled", rd_data1, 16'h0000);

        // Write-to-read bypass on port 2, then stored value after the edge.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
        rd_en2 = 1'b1; rd_addr2 = 4'd7;
        #1;
        check("r7_bypass", rd_data2, 16'h1234);
        tick();
        wr_en = 1'b0;
        #1;
        check("r7_stored", rd_data2, 16'h1234);
        rd_en2 = 1'b0;

        // Register 0: write ignored (also under bypass), issue ignored.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rd_en1 = 1'b1; rd_addr1 = 4'd0;
        #1;
        check("r0_bypass_zero", rd_data1, 16'h0000);
        tick();
        wr_en = 1'b0;
        #1;
        check("r0_read_zero", rd_data1, 16'h0000);
        iss_en = 1'b1; iss_addr = 4'd0;
        tick();
        iss_en = 1'b0;
        #1;
        check("r0_busy_zero", {15'd0, busy1}, 16'h0000);
        check("r0_stall_zero", {15'd0, stall}, 16'h0000);

        // Issue r3 twice (re-issue of busy index), then write-back.
        iss_en = 1'b1; iss_addr = 4'd3;
        tick();
        tick();
        iss_en = 1'b0;
        rd_addr1 = 4'd3;
        #1;
        check("r3_busy1", {15'd0, busy1}, 16'h0001);
        check("r3_stall", {15'd0, stall}, 16'h0001);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA;
        #1;
        check("r3_wb_busy1", {15'd0, busy1}, 16'h0000);
        check("r3_wb_stall", {15'd0, stall}, 16'h0000);
        check("r3_wb_bypass", rd_data1, 16'h00AA);
        tick();
        wr_en = 1'b0;
        #1;
        check("r3_after_busy1", {15'd0, busy1}, 16'h0000);
        check("r3_after_data", rd_data1, 16'h00AA);

        // r4 busy, then issue and write-back on r4 at the same edge.
        iss_en = 1'b1; iss_addr = 4'd4;
        tick();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h5555;
        rd_addr1 = 4'd4;
        #1;
        check("r4_wb_forced_idle", {15'd0, busy1}, 16'h0000);
        tick();
        iss_en = 1'b0;
        wr_en = 1'b0;
        rd_en2 = 1'b1; rd_addr2 = 4'd4;
        #1;
        check("r4_still_busy1", {15'd0, busy1}, 16'h0001);
        check("r4_still_busy2", {15'd0, busy2}, 16'h0001);
        check("r4_data", rd_data1, 16'h5555);

        // Issue r9 and write-back r4 on the same edge: both take effect.
        iss_en = 1'b1; iss_addr = 4'd9;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0042;
        tick();
        iss_en = 1'b0;
        wr_en = 1'b0;
        rd_addr2 = 4'd9;
        #1;
        check("r4_cleared", {15'd0, busy1}, 16'h0000);
        check("r4_new_data", rd_data1, 16'h0042);
        check("r9_busy2", {15'd0, busy2}, 16'h0001);
        check("r9_stall", {15'd0, stall}, 16'h0001);

        // Reset with write and issue asserted: bypass visible, state ignored.
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h7777;
        iss_en = 1'b1; iss_addr = 4'd6;
        rd_addr2 = 4'd6;
        #1;
        check("rst_bypass", rd_data2, 16'h7777);
        tick();
        rst = 1'b1;
        wr_en = 1'b0;
        iss_en = 1'b0;
        #1;
        check("rst_r6_data", rd_data2, 16'h0000);
        check("rst_r6_busy", {15'd0, busy2}, 16'h0000);
        check("rst_r4_data", rd_data1, 16'h0000);
        check("rst_r4_busy", {15'd0, busy1}, 16'h0000);
        rd_addr1 = 4'd5;
        rd_addr2 = 4'd9;
        #1;
        check("rst_r5_data", rd_data1, 16'h0000);
        check("rst_r9_busy", {15'd0, busy2}, 16'h0000);
        check("rst_stall", {15'd0, stall}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
